// File: rtl/usb_tx.sv
// USB low/full-speed transmitter: SYNC, bit stuffing, NRZI and EOP, advancing once per clk_en.
// Bytes arrive from the SIE over a valid/ready handshake and leave LSB first.
package types;
    typedef enum logic [1:0] {SE0 = 2'b00, J = 2'b01, K = 2'b10} d_port_t;
endpackage

module usb_tx
    import types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output d_port_t    d_o,
    output logic       oe,
    output logic       active
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP0, EOP1, EOP_J} state_t;

    state_t     state_q, state_d;
    d_port_t    line_q, line_d;
    logic       oe_q, oe_d;
    logic       active_q, active_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic [7:0] shift_q, shift_d;
    logic       need_load_q, need_load_d;
    logic       load_fire;
    logic       drive_bit;
    logic       bit_val;
    d_port_t    line_toggled;

    assign line_toggled = (line_q == J) ? K : J;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        oe_d        = oe_q;
        active_d    = active_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        shift_d     = shift_q;
        need_load_d = need_load_q;
        load_fire   = 1'b0;
        drive_bit   = 1'b0;
        bit_val     = 1'b0;

        case (state_q)
            IDLE: begin
                line_d    = J;
                oe_d      = 1'b0;
                ones_d    = 3'd0;
                bit_cnt_d = 3'd0;
                if (tx_valid) begin
                    state_d  = SYNC;
                    line_d   = K;
                    oe_d     = 1'b1;
                    active_d = 1'b1;
                end
            end
            SYNC: begin
                // Symbols 1..6 are data 0 (toggle); symbol 7 is the closing data 1 (hold).
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd6) begin
                    ones_d      = 3'd1;
                    bit_cnt_d   = 3'd0;
                    need_load_d = 1'b1;
                    state_d     = DATA;
                end else begin
                    line_d = line_toggled;
                    ones_d = 3'd0;
                end
            end
            DATA: begin
                if (ones_q == 3'd6) begin
                    line_d = line_toggled;
                    ones_d = 3'd0;
                end else if (need_load_q) begin
                    if (tx_valid) begin
                        load_fire   = 1'b1;
                        shift_d     = tx_data;
                        drive_bit   = 1'b1;
                        bit_val     = tx_data[0];
                        bit_cnt_d   = 3'd1;
                        need_load_d = 1'b0;
                    end else begin
                        line_d  = SE0;
                        state_d = EOP0;
                    end
                end else begin
                    drive_bit = 1'b1;
                    bit_val   = shift_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        need_load_d = 1'b1;
                    end
                end
            end
            EOP0: begin
                line_d  = SE0;
                state_d = EOP1;
            end
            EOP1: begin
                line_d  = J;
                state_d = EOP_J;
            end
            EOP_J: begin
                line_d   = J;
                oe_d     = 1'b0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // NRZI: a 0 toggles the line and breaks the run of ones, a 1 holds the line.
        if (drive_bit) begin
            if (bit_val) begin
                ones_d = ones_q + 3'd1;
            end else begin
                line_d = line_toggled;
                ones_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            line_q      <= J;
            oe_q        <= 1'b0;
            active_q    <= 1'b0;
            bit_cnt_q   <= 3'd0;
            ones_q      <= 3'd0;
            shift_q     <= 8'd0;
            need_load_q <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            line_q      <= line_d;
            oe_q        <= oe_d;
            active_q    <= active_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            shift_q     <= shift_d;
            need_load_q <= need_load_d;
        end
    end

    assign tx_ready = clk_en & load_fire & ~reset;
    assign d_o      = line_q;
    assign oe       = oe_q;
    assign active   = active_q;

endmodule

// File: tb/tb_usb_tx.sv
// Randomized bench for usb_tx: each packet's expected line symbols and byte-load edges come
// from a bit-stream model (SYNC bits, stuffing, NRZI) built before the packet is driven.
module tb_usb_tx;
    import types::*;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    d_port_t    d_o;
    logic       oe;
    logic       active;

    int n_checks;
    int n_fail;
    logic [7:0] pkt [0:7];

    usb_tx dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .d_o      (d_o),
        .oe       (oe),
        .active   (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // div: 1 = clk_en every clk, 2/3 = every Nth clk, 0 = random enable pattern
    task automatic run_packet(input int nb, input int div);
        d_port_t exp_sym[$];
        int      loads[$];
        d_port_t line;
        int      ones;
        int      k, bi, cyc, n_sym;
        logic    en, rdy;
        logic [7:0] sync_bits;
        logic [7:0] b;

        line = J;
        ones = 0;
        sync_bits = 8'b1000_0000;
        for (int i = 0; i < 8 + nb * 8; i++) begin
            logic bitv;
            if (i < 8) begin
                bitv = sync_bits[i];
            end else begin
                if ((i - 8) % 8 == 0) loads.push_back(exp_sym.size());
                b = pkt[(i - 8) / 8];
                bitv = b[(i - 8) % 8];
            end
            if (bitv) ones++;
            else begin
                line = (line == J) ? K : J;
                ones = 0;
            end
            exp_sym.push_back(line);
            if (ones == 6) begin
                line = (line == J) ? K : J;
                ones = 0;
                exp_sym.push_back(line);
            end
        end
        exp_sym.push_back(SE0);
        exp_sym.push_back(SE0);
        exp_sym.push_back(J);
        n_sym = exp_sym.size();

        tx_valid = 1'b1;
        tx_data  = (nb > 0) ? pkt[0] : 8'($urandom);
        k   = 0;
        bi  = 0;
        cyc = 0;
        while (k <= n_sym && cyc < 5000) begin
            @(negedge clk);
            en = (div == 0) ? 1'($urandom_range(0, 1)) : ((cyc % div) == 0);
            clk_en = en;
            #1;
            rdy = tx_ready;
            if (!en) check_val("ready_without_en", {31'd0, rdy}, 32'd0);
            else if (rdy) check_val("ready_edge", k, (bi < nb) ? loads[bi] : -1);
            @(posedge clk);
            #1;
            if (en) begin
                check_val("d_o", {30'd0, d_o}, {30'd0, (k < n_sym) ? exp_sym[k] : J});
                check_val("oe", {31'd0, oe}, {31'd0, k < n_sym});
                check_val("active", {31'd0, active}, {31'd0, k < n_sym});
                if (nb == 0 && k == 0) tx_valid = 1'b0;
                k++;
            end
            if (en && rdy) begin
                bi++;
                if (bi < nb) tx_data = pkt[bi];
                else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                end
            end
            cyc++;
        end
        if (cyc >= 5000) check_val("packet_timeout", 32'd1, 32'd0);
        check_val("ready_count", bi, nb);
        $display("packet nb=%0d div=%0d symbols=%0d ready_pulses=%0d", nb, div, n_sym, bi);
        tx_valid = 1'b0;
    endtask

    task automatic run_reset_midpacket();
        int   acc;
        logic rdy;
        pkt[0] = 8'h3C;
        pkt[1] = 8'h96;
        tx_valid = 1'b1;
        tx_data  = pkt[0];
        acc = 0;
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            clk_en = 1'b1;
            if (e == 10) reset = 1'b1;
            #1;
            rdy = tx_ready;
            if (rdy) check_val("rst_ready_edge", e, 8);
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                tx_data = pkt[1];
            end
        end
        check_val("rst_oe", {31'd0, oe}, 32'd0);
        check_val("rst_d_o", {30'd0, d_o}, {30'd0, J});
        check_val("rst_active", {31'd0, active}, 32'd0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            clk_en = 1'b1;
            #1;
            check_val("rst_no_ready", {31'd0, tx_ready}, 32'd0);
            @(posedge clk);
            #1;
            check_val("rst_idle_oe", {31'd0, oe}, 32'd0);
        end
        $display("reset mid-packet: accepted=%0d before reset", acc);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clk_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_d_o", {30'd0, d_o}, {30'd0, J});
        check_val("reset_oe", {31'd0, oe}, 32'd0);
        check_val("reset_active", {31'd0, active}, 32'd0);
        check_val("reset_ready", {31'd0, tx_ready}, 32'd0);
        $display("reset idle: d_o=%0d oe=%0b active=%0b", d_o, oe, active);
        @(negedge clk);
        reset = 1'b0;

        pkt[0] = 8'hA5; run_packet(1, 1);
        pkt[0] = 8'hFF; run_packet(1, 1);
        pkt[0] = 8'hFC; run_packet(1, 1);
        pkt[0] = 8'h00; pkt[1] = 8'h80; run_packet(2, 2);
        run_packet(0, 1);
        run_reset_midpacket();

        for (int t = 0; t < 12; t++) begin
            int nb;
            nb = $urandom_range(0, 4);
            for (int i = 0; i < 8; i++)
                pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            run_packet(nb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
# usb_tx

USB low/full-speed transmitter. It takes bytes from the SIE over a valid/ready handshake and serializes them onto the bus driver. It prepends SYNC, performs bit stuffing and NRZI encoding, and appends EOP. It runs at the bit rate set by `clk_en` from the shared clock/CDR front end, and mirrors the receive path.

## Interface
- No parameters.
- `clk`  in  1  system clock (24 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  bit-rate enable; one pulse per USB bit time.
- `tx_valid`  in  1  SIE has a byte on `tx_data`; held high for the whole packet, dropped after the last byte is accepted.
- `tx_data`  in  8  byte to send, LSB first; stable while `tx_valid`=1 until `tx_ready`.
- `tx_ready`  out  1  byte accepted; one-clk pulse.
- `d_o`  out  `d_port_t`  line state to bus driver (`J`, `K`, `SE0` from package `types`).
- `oe`  out  1  bus driver output enable.
- `active`  out  1  high from the first SYNC symbol through the EOP J symbol.

## Operation
- All state, `d_o`, `oe` and `active` are registered and update only on edges where `clk_en`=1. Each such edge is called "Ek" below.
- **FSM states:** IDLE, SYNC, DATA, EOP0, EOP1, EOP_J.
  - IDLE:
    - `d_o`=J, `oe`=0.
    - On `clk_en` with `tx_valid`=1 → SYNC. `d_o`<=K, `oe`<=1, `active`<=1, bit counter cleared.
  - SYNC: drives K J K J K J K K; the first K is driven on entry. After 8 symbols → DATA.
  - DATA, each edge, in priority order:
    - Stuff: if ones count is 6, drive a stuff bit (toggle line), clear ones count; no shift, no load.
    - Load: if a new byte is needed (first byte, or all 8 bits of the current byte sent):
      - If `tx_valid`=1: `tx_ready`=1, shift reg <= `tx_data`, drive bit 0.
      - Otherwise: `d_o`<=SE0 and go to EOP0.
    - Shift: otherwise, drive the next LSB-first bit.
  - EOP0 → EOP1: `d_o`<=SE0.
  - EOP1 → EOP_J: `d_o`<=J.
  - EOP_J → IDLE: `d_o`<=J, `oe`<=0, `active`<=0.
- **NRZI:** data 0 toggles the line (J↔K); data 1 holds it. Line state before SYNC is J.
- **Bit stuffing:**
  - 3-bit ones counter, cleared in IDLE.
  - SYNC counts as data 0000_0001, so the counter is 1 at the end of SYNC.
  - A data 1 increments the counter; a data 0 or a stuff bit clears it.
  - A stuff bit is inserted whenever the count reaches 6, including after the last bit of the last byte, before SE0.
- **`tx_ready`:** combinational, = `clk_en` & load & `tx_valid`, so `tx_data` is captured on that same edge. The SIE presents the next byte or drops `tx_valid` before the next load edge.
- A packet with zero bytes is legal: `tx_valid` dropped before E8 gives SYNC followed directly by EOP.
- `tx_valid` is only sampled in IDLE and at load edges; a drop mid-byte has no effect until the byte boundary.
- **Reset values:** `d_o`=J, `oe`=0, `active`=0, `tx_ready`=0, state IDLE, counters 0.
- **Reset mid-packet:** the bus is released on the next clk edge (`oe`=0); no EOP is sent.

## Timing
- **First SYNC K:** appears on `d_o` at E0, the `clk_en` edge where `tx_valid` is first seen in IDLE.
- **Byte 0:** loaded at E8 (`tx_ready` in the E8 clk cycle), bits driven E8..E15.
- **Next load:** at E16, plus one edge per stuff bit inserted in the byte.
- **EOP:** with the last byte ending at En-1 and no trailing stuff, SE0 at En and En+1, J at En+2, `oe`=0 at En+3.
- Each stuff bit delays all following symbols by one bit time.
- `tx_ready` is never asserted in a clk cycle where `clk_en`=0.

## Test plan
- Reset idle: `reset`=1 for 3 clk → `d_o`=J, `oe`=0, `active`=0, `tx_ready`=0.
- Single byte 0xA5 → `d_o` per bit time: KJKJKJKK, then KJJKJJKK, then SE0 SE0 J. `oe` high E0..E18, low at E19. One `tx_ready`, at E8.
- Byte 0xFF then `tx_valid` drop → after SYNC: K K K K K, J (stuff), J J J, then SE0 SE0 J. EOP starts at E17.
- Trailing stuff, byte 0xFC → data symbols J K K K K K K K, stuff J, then SE0. Six ones, stuff before EOP.
- Two bytes 0x00, 0x80 with `clk_en` every 2nd clk → `tx_ready` pulses one clk at E8 and E16. Byte 1 is taken only after the first pulse. Final EOP is correct.
- Zero-byte packet, and reset asserted at E10 of a 2-byte packet:
  - Zero-byte packet: SYNC then SE0 at E8.
  - Reset at E10: `oe`=0 and `d_o`=J on the next clk edge, FSM in IDLE, no `tx_ready` afterwards.
